div_tick_sync: RTL

- Receiving end of the ripple clock-divider output: takes a slow, asynchronous divided-clock signal into the system clk domain.
- Emits single-cycle rise/fall tick enables, measures the input period in clk cycles, and reports lock and stall status.
- Downstream logic uses the ticks as clock enables instead of clocking flops from divider outputs.

---
 rtl/div_tick_sync_pkg.sv | 27 ++
 rtl/div_edge_sync.sv | 64 ++++++
 rtl/div_tick_sync.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_tick_sync_pkg.sv
// div_tick_sync_pkg
//   Definitions shared by the divided-clock receiver and the ripple divider
//   that drives it.
//   - DIV_CNT_W / DIV_TIMEOUT : default period-counter width and stall timeout.
//     The divider uses the same width, so the receiver can always count one
//     full output period of the slowest divider tap.
//   - state_e : lock-tracking FSM states.
//   - dbg_t   : debug view of the receiver (FSM state and raw edge events).
package div_tick_sync_pkg;

  localparam int DIV_CNT_W   = 28;
  // Half of the counter range: a stall is declared well before saturation.
  localparam int DIV_TIMEOUT = 134217728;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  typedef struct packed {
    state_e state;
    logic   rise_ev;
    logic   fall_ev;
  } dbg_t;

endpackage

// File: rtl/div_edge_sync.sv
// div_edge_sync
//   Brings the asynchronous divided clock into the clk domain and turns its
//   edges into events and registered single-cycle ticks.
//   Ports:
//     clk, rst (sync, active-high)
//     div_in    : asynchronous divided-clock input
//     rise_ev   : combinational, synchronized level went 0 -> 1 this cycle
//     fall_ev   : combinational, synchronized level went 1 -> 0 this cycle
//     tick_rise : rise_ev delayed one cycle (registered, glitch-free)
//     tick_fall : fall_ev delayed one cycle
//   SYNC_STAGES must be at least 2.
module div_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic rise_ev,
  output logic fall_ev,
  output logic tick_rise,
  output logic tick_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_prev_q;
  logic                   s_prev_d;
  logic                   tick_rise_q;
  logic                   tick_rise_d;
  logic                   tick_fall_q;
  logic                   tick_fall_d;
  logic                   s;

  // Only sync_q[SYNC_STAGES-1] is ever compared against the history flop,
  // so a level that is seen once yields exactly one event, and a glitch
  // that is missed by stage 0 yields none.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], div_in};
    s           = sync_q[SYNC_STAGES-1];
    rise_ev     = s & ~s_prev_q;
    fall_ev     = ~s & s_prev_q;
    s_prev_d    = s;
    tick_rise_d = rise_ev;
    tick_fall_d = fall_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      s_prev_q    <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      s_prev_q    <= s_prev_d;
      tick_rise_q <= tick_rise_d;
      tick_fall_q <= tick_fall_d;
    end
  end

  assign tick_rise = tick_rise_q;
  assign tick_fall = tick_fall_q;

endmodule

// File: rtl/div_tick_sync.sv
// div_tick_sync
//   Receiving end of the ripple clock divider. Produces clock-enable ticks
//   for each edge of the divided clock, measures its rise-to-rise period in
//   clk cycles and tracks whether that period is stable (locked) or whether
//   the input has stopped toggling (stalled).
//   Ports:
//     clk, rst (sync, active-high)
//     div_in       : asynchronous divided-clock input
//     tick_rise    : one-cycle pulse per synchronized rising edge
//     tick_fall    : one-cycle pulse per synchronized falling edge
//     period       : last measured period in clk cycles (CNT_W bits)
//     period_valid : period holds a measurement taken since the last stall
//     locked       : LOCK_COUNT consecutive periods matched within TOL
//     stalled      : no rising edge for TIMEOUT cycles
//     dbg          : FSM state plus raw rise/fall events
//   Period behaviour:
//     The first rise after reset or stall only starts the measurement; the
//     second rise produces the first period. A match compares each new
//     period with the previous one, so slow drift is tolerated.
module div_tick_sync
  import div_tick_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DIV_CNT_W,
  parameter int TIMEOUT     = DIV_TIMEOUT,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stalled,
  output dbg_t             dbg
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W:0]   DIFF_ONE  = (CNT_W + 1)'(1);
  localparam logic [MC_W-1:0]  MC_LOCK   = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]  MC_ONE    = MC_W'(1);

  logic rise_ev;
  logic fall_ev;

  div_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .div_in   (div_in),
    .rise_ev  (rise_ev),
    .fall_ev  (fall_ev),
    .tick_rise(tick_rise),
    .tick_fall(tick_fall)
  );

  state_e            state_q;
  state_e            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  period_d;
  logic              period_valid_q;
  logic              period_valid_d;
  logic              locked_q;
  logic              locked_d;
  logic              stalled_q;
  logic              stalled_d;
  logic [MC_W-1:0]   match_cnt_q;
  logic [MC_W-1:0]   match_cnt_d;

  logic [CNT_W-1:0]  cnt_inc;     // saturating cnt+1, also the measured value m
  logic [CNT_W:0]    diff;        // m - period with a spare sign bit
  logic [CNT_W:0]    abs_diff;
  logic              is_match;
  logic              timeout_hit;
  logic [MC_W-1:0]   mc_inc;

  // Datapath: saturating increment, non-wrapping distance, match test.
  always_comb begin
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    diff        = {1'b0, cnt_inc} - {1'b0, period_q};
    abs_diff    = diff[CNT_W] ? (~diff + DIFF_ONE) : diff;
    is_match    = period_valid_q && (abs_diff <= TOL_C);
    timeout_hit = (cnt_inc == TIMEOUT_C);
    mc_inc      = (match_cnt_q == MC_LOCK) ? match_cnt_q : match_cnt_q + MC_ONE;
  end

  // Lock-tracking FSM. rise_ev is tested before the timeout so a rise on
  // the timeout cycle keeps the measurement alive.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    locked_d       = locked_q;
    stalled_d      = stalled_q;
    match_cnt_d    = match_cnt_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rise_ev) begin
          state_d     = MEASURE;
          stalled_d   = 1'b0;
          match_cnt_d = '0;
        end
      end

      MEASURE: begin
        if (rise_ev) begin
          cnt_d          = '0;
          period_d       = cnt_inc;
          period_valid_d = 1'b1;
          if (is_match) begin
            match_cnt_d = mc_inc;
            if (mc_inc == MC_LOCK) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end else if (timeout_hit) begin
          state_d        = IDLE;
          cnt_d          = '0;
          stalled_d      = 1'b1;
          locked_d       = 1'b0;
          period_valid_d = 1'b0;
          match_cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      LOCKED: begin
        if (rise_ev) begin
          cnt_d    = '0;
          period_d = cnt_inc;
          if (is_match) begin
            match_cnt_d = mc_inc;
          end else begin
            state_d     = MEASURE;
            locked_d    = 1'b0;
            match_cnt_d = '0;
          end
        end else if (timeout_hit) begin
          state_d        = IDLE;
          cnt_d          = '0;
          stalled_d      = 1'b1;
          locked_d       = 1'b0;
          period_valid_d = 1'b0;
          match_cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stalled_q      <= 1'b0;
      match_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stalled_q      <= stalled_d;
      match_cnt_q    <= match_cnt_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stalled      = stalled_q;

  always_comb begin
    dbg.state   = state_q;
    dbg.rise_ev = rise_ev;
    dbg.fall_ev = fall_ev;
  end

endmodule
